// File: rtl/bcd_tens_display.sv
// Takes the units digit from an asynchronous MOD-10 counter into the CLK domain and filters it.
// It keeps a MOD-10 tens digit from wrap events and multiplexes both digits onto a seven-segment display.
module bcd_tens_display #(
    parameter int REFRESH_DIV    = 1000,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit BLANK_LZ       = 1'b1
) (
    input  logic       CLK,
    input  logic       RESET_0,
    input  logic       COUNTER_ACTIVE,
    input  logic       UP_DOWN,
    input  logic [3:0] UNITS_IN,
    output logic [3:0] TENS_OUT,
    output logic [3:0] UNITS_OUT,
    output logic       CARRY,
    output logic       BORROW,
    output logic       ERR,
    output logic [6:0] SEG_OUT,
    output logic [1:0] DIGIT_EN
);

    localparam int         CW      = $clog2(REFRESH_DIV);
    localparam logic [6:0] SEG_OFF = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic [6:0] SEG_DASH = 7'h40;

    // Two-flop synchronizers (S1 then S2) for all counter-domain signals
    logic [3:0] units_s1_q, units_s2_q;
    logic       up_s1_q, up_s2_q;
    logic       act_s1_q, act_s2_q;

    logic [3:0]    units_q, units_d;
    logic [3:0]    tens_q, tens_d;
    logic          carry_q, carry_d;
    logic          borrow_q, borrow_d;
    logic          err_q, err_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          slot_q, slot_d;
    logic [1:0]    digit_en_q, digit_en_d;
    logic [6:0]    seg_q, seg_d;

    logic       stable;
    logic       accept;
    logic       invalid;
    logic [6:0] seg_raw;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h3F;
            4'd1:    s = 7'h06;
            4'd2:    s = 7'h5B;
            4'd3:    s = 7'h4F;
            4'd4:    s = 7'h66;
            4'd5:    s = 7'h6D;
            4'd6:    s = 7'h7D;
            4'd7:    s = 7'h07;
            4'd8:    s = 7'h7F;
            4'd9:    s = 7'h6F;
            default: s = 7'h00;
        endcase
        return s;
    endfunction

    always_ff @(posedge CLK or negedge RESET_0) begin
        if (!RESET_0) begin
            units_s1_q <= 4'd0;
            units_s2_q <= 4'd0;
            up_s1_q    <= 1'b0;
            up_s2_q    <= 1'b0;
            act_s1_q   <= 1'b0;
            act_s2_q   <= 1'b0;
        end else begin
            units_s1_q <= UNITS_IN;
            units_s2_q <= units_s1_q;
            up_s1_q    <= UP_DOWN;
            up_s2_q    <= up_s1_q;
            act_s1_q   <= COUNTER_ACTIVE;
            act_s2_q   <= act_s1_q;
        end
    end

    assign stable  = (units_s2_q == units_s1_q);
    assign accept  = stable && (units_s2_q != units_q) && (units_s2_q <= 4'd9);
    assign invalid = stable && (units_s2_q > 4'd9);

    // Wrap detection compares the previously accepted digit against the newly accepted one
    always_comb begin
        units_d  = units_q;
        tens_d   = tens_q;
        carry_d  = 1'b0;
        borrow_d = 1'b0;
        err_d    = err_q | invalid;
        if (accept) begin
            units_d = units_s2_q;
            if (units_q == 4'd9 && units_s2_q == 4'd0 && up_s2_q && act_s2_q) begin
                tens_d  = (tens_q == 4'd9) ? 4'd0 : tens_q + 4'd1;
                carry_d = 1'b1;
            end else if (units_q == 4'd0 && units_s2_q == 4'd9 && !up_s2_q && act_s2_q) begin
                tens_d   = (tens_q == 4'd0) ? 4'd9 : tens_q - 4'd1;
                borrow_d = 1'b1;
            end
        end
    end

    // The display follows the next slot so DIGIT_EN flips on the same edge the count wraps
    always_comb begin
        cnt_d  = cnt_q + CW'(1);
        slot_d = slot_q;
        if (cnt_q == CW'(REFRESH_DIV - 1)) begin
            cnt_d  = '0;
            slot_d = ~slot_q;
        end
        seg_raw    = 7'h00;
        digit_en_d = 2'b01;
        if (!slot_d) begin
            seg_raw = err_q ? SEG_DASH : seg7(units_q);
        end else begin
            digit_en_d = 2'b10;
            seg_raw    = (BLANK_LZ && tens_q == 4'd0) ? 7'h00 : seg7(tens_q);
        end
        seg_d = SEG_ACTIVE_LOW ? ~seg_raw : seg_raw;
    end

    always_ff @(posedge CLK or negedge RESET_0) begin
        if (!RESET_0) begin
            units_q    <= 4'd0;
            tens_q     <= 4'd0;
            carry_q    <= 1'b0;
            borrow_q   <= 1'b0;
            err_q      <= 1'b0;
            cnt_q      <= '0;
            slot_q     <= 1'b0;
            digit_en_q <= 2'b00;
            seg_q      <= SEG_OFF;
        end else begin
            units_q    <= units_d;
            tens_q     <= tens_d;
            carry_q    <= carry_d;
            borrow_q   <= borrow_d;
            err_q      <= err_d;
            cnt_q      <= cnt_d;
            slot_q     <= slot_d;
            digit_en_q <= digit_en_d;
            seg_q      <= seg_d;
        end
    end

    assign UNITS_OUT = units_q;
    assign TENS_OUT  = tens_q;
    assign CARRY     = carry_q;
    assign BORROW    = borrow_q;
    assign ERR       = err_q;
    assign SEG_OUT   = seg_q;
    assign DIGIT_EN  = digit_en_q;

endmodule

// File: tb/tb_bcd_tens_display.sv
// Directed bench for bcd_tens_display: a sample-history model checked every cycle,
// plus hand-computed checkpoints for reset, carry/borrow, gating, glitch, error and multiplexing.
module tb_bcd_tens_display;

    localparam int DIV = 4;

    logic       CLK = 1'b0;
    logic       RESET_0 = 1'b1;
    logic       COUNTER_ACTIVE = 1'b1;
    logic       UP_DOWN = 1'b1;
    logic [3:0] UNITS_IN = 4'd0;
    logic [3:0] TENS_OUT, UNITS_OUT;
    logic       CARRY, BORROW, ERR;
    logic [6:0] SEG_OUT;
    logic [1:0] DIGIT_EN;

    int tests = 0;
    int fails = 0;
    int carry_cnt = 0;
    int borrow_cnt = 0;

    bcd_tens_display #(
        .REFRESH_DIV(DIV),
        .SEG_ACTIVE_LOW(1'b0),
        .BLANK_LZ(1'b1)
    ) dut (
        .CLK(CLK),
        .RESET_0(RESET_0),
        .COUNTER_ACTIVE(COUNTER_ACTIVE),
        .UP_DOWN(UP_DOWN),
        .UNITS_IN(UNITS_IN),
        .TENS_OUT(TENS_OUT),
        .UNITS_OUT(UNITS_OUT),
        .CARRY(CARRY),
        .BORROW(BORROW),
        .ERR(ERR),
        .SEG_OUT(SEG_OUT),
        .DIGIT_EN(DIGIT_EN)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a digit is taken when the same value was sampled at the two previous edges
    int         seg_tab[10] = '{'h3F, 'h06, 'h5B, 'h4F, 'h66, 'h6D, 'h7D, 'h07, 'h7F, 'h6F};
    int         m_units = 0, m_tens = 0, m_err = 0, m_carry = 0, m_borrow = 0;
    int         m_en = 0, m_seg = 0, m_edges = 0;
    logic [3:0] h1 = 0, h2 = 0;
    logic       u1 = 0, u2 = 0, a1 = 0, a2 = 0;

    always @(posedge CLK or negedge RESET_0) begin
        if (!RESET_0) begin
            m_units = 0; m_tens = 0; m_err = 0; m_carry = 0; m_borrow = 0;
            m_en = 0; m_seg = 0; m_edges = 0;
            h1 = 0; h2 = 0; u1 = 0; u2 = 0; a1 = 0; a2 = 0;
        end else begin
            m_edges++;
            if (((m_edges / DIV) % 2) == 0) begin
                m_en  = 1;
                m_seg = (m_err != 0) ? 'h40 : seg_tab[m_units];
            end else begin
                m_en  = 2;
                m_seg = (m_tens == 0) ? 0 : seg_tab[m_tens];
            end
            m_carry = 0;
            m_borrow = 0;
            if (h1 == h2) begin
                if (h2 > 9) m_err = 1;
                else if (int'(h2) != m_units) begin
                    if (m_units == 9 && h2 == 0 && u2 && a2) begin
                        m_tens = (m_tens + 1) % 10;
                        m_carry = 1;
                    end else if (m_units == 0 && h2 == 9 && !u2 && a2) begin
                        m_tens = (m_tens + 9) % 10;
                        m_borrow = 1;
                    end
                    m_units = int'(h2);
                end
            end
            h2 = h1; h1 = UNITS_IN;
            u2 = u1; u1 = UP_DOWN;
            a2 = a1; a1 = COUNTER_ACTIVE;
        end
    end

    always @(posedge CLK) begin
        #1;
        chk("units", UNITS_OUT, m_units);
        chk("tens", TENS_OUT, m_tens);
        chk("carry", CARRY, m_carry);
        chk("borrow", BORROW, m_borrow);
        chk("err", ERR, m_err);
        chk("digit_en", DIGIT_EN, m_en);
        chk("seg", SEG_OUT, m_seg);
        if (CARRY === 1'b1) carry_cnt++;
        if (BORROW === 1'b1) borrow_cnt++;
    end

    task automatic drive(input logic [3:0] v, input int n);
        @(negedge CLK);
        UNITS_IN = v;
        repeat (n) @(posedge CLK);
    endtask

    task automatic wait_en(input logic [1:0] target);
        int k = 0;
        @(posedge CLK);
        #1;
        while (k < 20 && DIGIT_EN !== target) begin
            @(posedge CLK);
            #1;
            k++;
        end
        chk("wait_digit_en", DIGIT_EN, target);
    endtask

    task automatic mid_reset();
        @(negedge CLK);
        UNITS_IN = 4'd0;
        #2 RESET_0 = 1'b0;
        #1;
        chk("rst_tens", TENS_OUT, 0);
        chk("rst_units", UNITS_OUT, 0);
        chk("rst_digit_en", DIGIT_EN, 0);
        chk("rst_seg", SEG_OUT, 0);
        chk("rst_err", ERR, 0);
        @(negedge CLK);
        RESET_0 = 1'b1;
        @(posedge CLK);
        #1;
        chk("post_rst_digit_en", DIGIT_EN, 2'b01);
        chk("post_rst_seg", SEG_OUT, 7'h3F);
    endtask

    initial begin
        int n;
        #1 RESET_0 = 1'b0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RESET_0 = 1'b1;
        @(posedge CLK);
        #1;
        chk("first_digit_en", DIGIT_EN, 2'b01);
        chk("first_seg", SEG_OUT, 7'h3F);

        // Carry chain: three full 0..9,0 sweeps counting up
        carry_cnt = 0;
        for (int r = 0; r < 3; r++) begin
            for (int d = 1; d <= 9; d++) drive(4'(d), 5);
            drive(4'd0, 5);
        end
        chk("chain_carry_count", carry_cnt, 3);
        chk("chain_tens", TENS_OUT, 3);

        // Reset mid-slot with tens = 3, then borrow wrap 0 -> 9
        repeat (2) @(posedge CLK);
        mid_reset();
        UP_DOWN = 1'b0;
        borrow_cnt = 0;
        drive(4'd0, 3);
        drive(4'd9, 5);
        chk("borrow_tens", TENS_OUT, 9);
        chk("borrow_count", borrow_cnt, 1);

        // Gated 9 -> 0, then 0 -> 9 and 9 -> 5 counting up
        carry_cnt = 0;
        COUNTER_ACTIVE = 1'b0;
        UP_DOWN = 1'b1;
        drive(4'd9, 3);
        drive(4'd0, 5);
        chk("gated_units", UNITS_OUT, 0);
        chk("gated_tens", TENS_OUT, 9);
        COUNTER_ACTIVE = 1'b1;
        drive(4'd9, 5);
        drive(4'd5, 5);
        chk("jump_units", UNITS_OUT, 5);
        chk("jump_tens", TENS_OUT, 9);

        // One-cycle 0 between 9s is a glitch
        drive(4'd9, 5);
        drive(4'd0, 1);
        drive(4'd9, 5);
        chk("glitch_units", UNITS_OUT, 9);
        chk("glitch_tens", TENS_OUT, 9);
        chk("glitch_carry_count", carry_cnt, 0);

        // Multiplex with blanked tens, then tens = 2
        mid_reset();
        wait_en(2'b10);
        chk("blank_tens_seg", SEG_OUT, 7'h00);
        n = 0;
        while (n < 20 && DIGIT_EN === 2'b10) begin
            @(posedge CLK);
            #1;
            n++;
        end
        chk("tens_slot_len", n, DIV);
        chk("units_slot_seg", SEG_OUT, 7'h3F);
        for (int r = 0; r < 2; r++) begin
            for (int d = 1; d <= 9; d++) drive(4'(d), 4);
            drive(4'd0, 4);
        end
        chk("mux_tens", TENS_OUT, 2);
        wait_en(2'b01);
        wait_en(2'b10);
        chk("tens2_seg", SEG_OUT, 7'h5B);

        // Out-of-range value held steady
        drive(4'd12, 4);
        chk("err_flag", ERR, 1);
        chk("err_units_held", UNITS_OUT, 0);
        wait_en(2'b10);
        wait_en(2'b01);
        chk("err_dash_seg", SEG_OUT, 7'h40);
        drive(4'd3, 5);
        chk("err_sticky", ERR, 1);

        repeat (2) @(posedge CLK);
        #2;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/bcd_tens_display.md
# bcd_tens_display

Downstream consumer of the asynchronous MOD-10 up/down counter's 4-bit output. Brings the units digit into the system clock domain and filters it. Detects 9->0 and 0->9 wrap events to keep a MOD-10 tens digit. Time-multiplexes units and tens onto a two-digit seven-segment display.

## Interface
- REFRESH_DIV, default 1000: CLK cycles per display digit slot (>= 2).
- SEG_ACTIVE_LOW, default 1: 1 means SEG_OUT bits are driven low to light a segment.
- BLANK_LZ, default 1: 1 blanks the tens digit while TENS_OUT == 0.

- CLK, input, 1: system clock. All state is updated on posedge.
- RESET_0, input, 1: reset. Asynchronous, active-low.
- COUNTER_ACTIVE, input, 1: counter enable (async). Carry and borrow are counted only while it is high.
- UP_DOWN, input, 1: counter direction (async). 1 = up.
- UNITS_IN, input, 4: counter DATA_OUT (async, counter-clock domain).
- TENS_OUT, output, 4: tens digit, 0..9.
- UNITS_OUT, output, 4: accepted units digit, 0..9.
- CARRY, output, 1: one-CLK pulse when tens increments.
- BORROW, output, 1: one-CLK pulse when tens decrements.
- ERR, output, 1: sticky flag for a stable UNITS_IN > 9.
- SEG_OUT, output, 7: segment drive, bit0 = a … bit6 = g.
- DIGIT_EN, output, 2: one-hot digit select, active-high. Bit0 = units, bit1 = tens.

## Operation
- Synchronizer: UNITS_IN, UP_DOWN and COUNTER_ACTIVE each pass through two flops, S1 then S2.
- Stability filter: A new value is accepted into UNITS_OUT only when all of these hold:
  - S2 == S1;
  - S2 != UNITS_OUT;
  - S2 <= 9.
- Invalid value: if S2 == S1 and S2 > 9, ERR is set and UNITS_OUT is held. Only reset clears ERR.
- Wrap detection is evaluated on an accept, comparing the old UNITS_OUT (p) with the new value (n), using synchronized UP_DOWN and COUNTER_ACTIVE:
  - p == 9, n == 0, UP_DOWN = 1, COUNTER_ACTIVE = 1: TENS_OUT = (TENS_OUT + 1) mod 10, and CARRY pulses.
  - p == 0, n == 9, UP_DOWN = 0, COUNTER_ACTIVE = 1: TENS_OUT = (TENS_OUT == 0 ? 9 : TENS_OUT - 1), and BORROW pulses.
  - Any other accept, including jumps such as 9->5 or 0->9 with UP_DOWN = 1, leaves TENS_OUT unchanged with no pulse.
- CARRY and BORROW are mutually exclusive. At most one event occurs per accept.
- Refresh counter: counts 0..REFRESH_DIV-1. At the terminal count it wraps to 0 and the slot bit toggles.
- Display outputs are registered every CLK:
  - slot 0: DIGIT_EN = 01, digit = UNITS_OUT;
  - slot 1: DIGIT_EN = 10, digit = TENS_OUT.
- Segment decode, active-high form, hex with a = bit0:
  - 0 = 3F, 1 = 06, 2 = 5B, 3 = 4F, 4 = 66;
  - 5 = 6D, 6 = 7D, 7 = 07, 8 = 7F, 9 = 6F.
- Blanking: the tens slot with BLANK_LZ = 1 and TENS_OUT == 0 decodes to 00.
- Polarity: when SEG_ACTIVE_LOW = 1, the decode is inverted before it is registered to SEG_OUT.
- Error display: while ERR is set, the units slot shows 40 (dash) instead of UNITS_OUT.

## Timing
- Reset values:
  - S1, S2 = 0; UNITS_OUT = 0, TENS_OUT = 0;
  - CARRY = 0, BORROW = 0, ERR = 0;
  - refresh count = 0, slot = 0, DIGIT_EN = 00;
  - SEG_OUT = all segments off (7F when active-low, 00 when active-high).
- After reset: on the first CLK edge after RESET_0 deasserts, DIGIT_EN = 01 and SEG_OUT shows 0.
- Latency:
  - A UNITS_IN change that is held steady appears in S1 at edge 1 and in S2 at edge 2.
  - UNITS_OUT, TENS_OUT, CARRY or BORROW, and ERR update at edge 3.
  - SEG_OUT reflects the new digit at edge 4 if that digit's slot is active.
- CARRY and BORROW are high for exactly one cycle. They are deasserted at the next edge.
- Glitch rule: a value that lives in S2 for only one cycle (S2 != S1) is never accepted.
- Reset mid-operation: all state and outputs return to their reset values immediately, without waiting for CLK.
- Slot period: each slot lasts REFRESH_DIV cycles. DIGIT_EN changes on the same edge that the refresh count wraps.

## Test plan
Simulation uses REFRESH_DIV = 4 and SEG_ACTIVE_LOW = 0.
- Reset: pulse RESET_0 low mid-slot. Outputs go to 0 and 00 immediately. After release, DIGIT_EN = 01 and SEG_OUT = 3F one edge later.
- Carry chain: with COUNTER_ACTIVE = 1 and UP_DOWN = 1, step UNITS_IN 0..9 then 0, holding each value for 5 clocks, three full times. TENS_OUT reaches 3 with exactly 3 single-cycle CARRY pulses, each 3 edges after the 9->0 change.
- Borrow wrap: from tens = 0 and units = 0, with UP_DOWN = 0, drive UNITS_IN = 9. TENS_OUT = 9 and BORROW pulses once.
- Gating and jumps:
  - 9->0 with COUNTER_ACTIVE = 0: no CARRY, TENS_OUT unchanged, UNITS_OUT = 0.
  - 9->5 with UP_DOWN = 1: no event.
- Glitch and error:
  - A one-cycle UNITS_IN = 0 pulse between 9s: no accept and no CARRY.
  - UNITS_IN = 12 held for 4 clocks: ERR = 1, UNITS_OUT held, units slot SEG_OUT = 40.
- Multiplex: with TENS_OUT = 0 and BLANK_LZ = 1, the tens slot shows SEG_OUT = 00. DIGIT_EN alternates 01/10 every 4 cycles. With tens = 2, the tens slot shows 5B.
